// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame constants
// used by both the receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..BAUD_DIV-1 and pulses tick on the last
// count. A synchronous clear holds the counter at 0.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receiver with 16x oversampling, mid-bit sampling and a one-entry
// valid/ready output buffer. Define UART_RX_PARITY_EN for an even-parity bit.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 27,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_frame_err,
    output logic                 m_parity_err,
    output logic                 rx_busy,
    output logic                 rx_overrun
);

    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam int BCNT_W = $clog2(DATA_BITS);
    localparam logic [SCNT_W-1:0] HALF_LAST = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] FULL_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(DATA_BITS - 1);

    logic sync_meta;
    logic sync_line;
    logic line_prev;
    logic fall;

    rx_state_t            state;
    logic [SCNT_W-1:0]    sample_cnt;
    logic [BCNT_W-1:0]    bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_err;
    logic                 baud_clear;
    logic                 tick;
    logic                 mid_tick;
    logic                 bit_tick;

    // Idle-high reset values keep a reset release from looking like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync_line <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync_meta <= rx_in;
            sync_line <= sync_meta;
            line_prev <= sync_line;
        end
    end

    assign fall = line_prev && !sync_line;

    assign baud_clear = (state == RX_IDLE);

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (baud_clear),
        .tick  (tick)
    );

    assign mid_tick = tick && (sample_cnt == HALF_LAST);
    assign bit_tick = tick && (sample_cnt == FULL_LAST);
    assign rx_busy  = (state != RX_IDLE);

`ifndef UART_RX_PARITY_EN
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RX_IDLE;
            sample_cnt   <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            m_frame_err  <= 1'b0;
            m_parity_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err      <= 1'b0;
`endif
        end else begin
            rx_overrun <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (tick) begin
                sample_cnt <= sample_cnt + 1'b1;
            end

            case (state)
                RX_IDLE: begin
                    sample_cnt <= '0;
                    bit_cnt    <= '0;
                    if (fall) begin
                        state <= RX_START;
                    end
                end

                // A line that is high again at the start-bit centre was a glitch.
                RX_START: begin
                    if (mid_tick) begin
                        sample_cnt <= '0;
                        state      <= sync_line ? RX_IDLE : RX_DATA;
                    end
                end

                RX_DATA: begin
                    if (bit_tick) begin
                        sample_cnt <= '0;
                        shift      <= {sync_line, shift[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= RX_PARITY;
`else
                            state   <= RX_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (bit_tick) begin
                        sample_cnt <= '0;
                        par_err    <= (^shift) ^ sync_line;
                        state      <= RX_STOP;
                    end
                end
`endif

                // The slot frees up in the same cycle the consumer takes the old byte.
                RX_STOP: begin
                    if (bit_tick) begin
                        sample_cnt <= '0;
                        state      <= RX_IDLE;
                        if (!m_valid || m_ready) begin
                            m_valid      <= 1'b1;
                            m_data       <= shift;
                            m_frame_err  <= !sync_line;
                            m_parity_err <= par_err;
                        end else begin
                            rx_overrun <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_uart_rx_oversampled;

    localparam int BAUD_DIV   = 4;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int BIT_CYC    = BAUD_DIV * OVERSAMPLE;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int STOP_MID = (DATA_BITS + 2) * BIT_CYC + BIT_CYC / 2;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int STOP_MID = (DATA_BITS + 1) * BIT_CYC + BIT_CYC / 2;
`endif
    localparam int LAT_MIN = STOP_MID;
    localparam int LAT_MAX = STOP_MID + 6;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 rx_in;
    logic                 m_valid;
    logic                 m_ready;
    logic [DATA_BITS-1:0] m_data;
    logic                 m_frame_err;
    logic                 m_parity_err;
    logic                 rx_busy;
    logic                 rx_overrun;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } rec_t;

    rec_t got_q[$];
    rec_t exp_q[$];
    int   rise_q[$];
    int   ovr_q[$];
    int   cyc = 0;
    logic valid_d = 1'b0;
    int   tests_run = 0;
    int   fails = 0;

    uart_rx_oversampled #(
        .BAUD_DIV   (BAUD_DIV),
        .OVERSAMPLE (OVERSAMPLE),
        .DATA_BITS  (DATA_BITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_in        (rx_in),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_frame_err  (m_frame_err),
        .m_parity_err (m_parity_err),
        .rx_busy      (rx_busy),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rec_t r;
        if (m_valid && !valid_d) rise_q.push_back(cyc);
        valid_d = m_valid;
        if (m_valid && m_ready) begin
            r.data = m_data;
            r.fe   = m_frame_err;
            r.pe   = m_parity_err;
            got_q.push_back(r);
        end
        if (rx_overrun) ovr_q.push_back(cyc);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        step(BIT_CYC);
    endtask

    task automatic clear_logs();
        got_q.delete();
        exp_q.delete();
        rise_q.delete();
        ovr_q.delete();
    endtask

    // Reference model of one frame as seen by the consumer.
    function automatic rec_t model(input logic [7:0] d, input logic stop, input logic flip);
        rec_t r;
        r.data = d;
        r.fe   = !stop;
        r.pe   = PAR_EN ? flip : 1'b0;
        return r;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip,
                              output int c0);
        step(1);
        c0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit((^d) ^ flip);
        drive_bit(stop);
    endtask

    task automatic compare_queues(input string name);
        tests_run++;
        if (got_q.size() !== exp_q.size()) begin
            fails++;
            $display("FAIL %s_count: got %0d bytes, want %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests_run++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].fe !== exp_q[i].fe ||
                got_q[i].pe !== exp_q[i].pe) begin
                fails++;
                $display("FAIL %s_byte%0d: got %h fe=%b pe=%b, want %h fe=%b pe=%b", name, i,
                         got_q[i].data, got_q[i].fe, got_q[i].pe,
                         exp_q[i].data, exp_q[i].fe, exp_q[i].pe);
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        rx_in   = 1'b1;
        m_ready = 1'b1;
        step(5);
        tests_run++;
        if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        tests_run++;
        if (m_data !== '0) begin fails++; $display("FAIL reset_data: got %h want 00", m_data); end
        tests_run++;
        if (m_frame_err !== 1'b0) begin fails++; $display("FAIL reset_fe: got %b want 0", m_frame_err); end
        tests_run++;
        if (m_parity_err !== 1'b0) begin fails++; $display("FAIL reset_pe: got %b want 0", m_parity_err); end
        tests_run++;
        if (rx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        tests_run++;
        if (rx_overrun !== 1'b0) begin fails++; $display("FAIL reset_ovr: got %b want 0", rx_overrun); end
        rst_n = 1'b1;
        step(20);
    endtask

    task automatic test_single_frame();
        int c0;
        clear_logs();
        send_frame(8'hA5, 1'b1, 1'b0, c0);
        exp_q.push_back(model(8'hA5, 1'b1, 1'b0));
        step(100);
        compare_queues("single");
        tests_run++;
        if (rise_q.size() != 1) begin
            fails++;
            $display("FAIL single_pulses: got %0d valid rises, want 1", rise_q.size());
        end else if (rise_q[0] - c0 < LAT_MIN || rise_q[0] - c0 > LAT_MAX) begin
            fails++;
            $display("FAIL single_latency: got %0d cycles, want %0d..%0d", rise_q[0] - c0, LAT_MIN, LAT_MAX);
        end
        tests_run++;
        if (rx_busy !== 1'b0) begin fails++; $display("FAIL single_busy: got %b want 0", rx_busy); end
    endtask

    task automatic test_glitch();
        clear_logs();
        rx_in = 1'b0;
        step(10);
        tests_run++;
        if (rx_busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_start: got %b want 1", rx_busy); end
        step(10);
        rx_in = 1'b1;
        step(100);
        tests_run++;
        if (rx_busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_end: got %b want 0", rx_busy); end
        compare_queues("glitch");
        tests_run++;
        if (ovr_q.size() != 0) begin fails++; $display("FAIL glitch_ovr: got %0d pulses, want 0", ovr_q.size()); end
    endtask

    task automatic test_break();
        int c0;
        clear_logs();
        send_frame(8'h3C, 1'b0, 1'b0, c0);
        exp_q.push_back(model(8'h3C, 1'b0, 1'b0));
        step(500);
        tests_run++;
        if (rx_busy !== 1'b0) begin fails++; $display("FAIL break_retrigger: busy got %b want 0", rx_busy); end
        rx_in = 1'b1;
        step(100);
        compare_queues("break");
    endtask

    task automatic test_overrun();
        int c0;
        int c1;
        clear_logs();
        m_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, c0);
        step(20);
        send_frame(8'h22, 1'b1, 1'b0, c1);
        step(50);
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 8'h11) begin
            fails++;
            $display("FAIL ovr_hold: got valid=%b data=%h, want valid=1 data=11", m_valid, m_data);
        end
        tests_run++;
        if (ovr_q.size() != 1) begin
            fails++;
            $display("FAIL ovr_pulses: got %0d, want 1", ovr_q.size());
        end else if (ovr_q[0] - c1 < LAT_MIN || ovr_q[0] - c1 > LAT_MAX) begin
            fails++;
            $display("FAIL ovr_time: got %0d cycles, want %0d..%0d", ovr_q[0] - c1, LAT_MIN, LAT_MAX);
        end
        m_ready = 1'b1;
        step(3);
        exp_q.push_back(model(8'h11, 1'b1, 1'b0));
        compare_queues("ovr_accept");
        tests_run++;
        if (m_valid !== 1'b0) begin fails++; $display("FAIL ovr_release: valid got %b want 0", m_valid); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int c0;
        clear_logs();
        send_frame(8'h07, 1'b1, 1'b1, c0);
        rx_in = 1'b1;
        step(40);
        send_frame(8'h07, 1'b1, 1'b0, c0);
        rx_in = 1'b1;
        step(100);
        exp_q.push_back(model(8'h07, 1'b1, 1'b1));
        exp_q.push_back(model(8'h07, 1'b1, 1'b0));
        compare_queues("parity");
    endtask
`endif

    task automatic test_random();
        int   c0;
        logic [7:0] d;
        logic stop;
        logic flip;
        clear_logs();
        for (int n = 0; n < 10; n++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            flip = PAR_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            send_frame(d, stop, flip, c0);
            exp_q.push_back(model(d, stop, flip));
            rx_in = 1'b1;
            step($urandom_range(8, 80));
        end
        step(50);
        compare_queues("random");
    endtask

    task automatic test_back_to_back();
        int c0;
        logic [7:0] d;
        clear_logs();
        for (int n = 0; n < 4; n++) begin
            d = 8'($urandom_range(0, 255));
            send_frame(d, 1'b1, 1'b0, c0);
            exp_q.push_back(model(d, 1'b1, 1'b0));
        end
        rx_in = 1'b1;
        step(50);
        compare_queues("b2b");
    endtask

    task automatic test_reset_midframe();
        int c0;
        clear_logs();
        m_ready = 1'b0;
        send_frame(8'h99, 1'b1, 1'b0, c0);
        rx_in = 1'b1;
        step(20);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        tests_run++;
        if (rx_busy !== 1'b1 || m_valid !== 1'b1) begin
            fails++;
            $display("FAIL midrst_pre: got busy=%b valid=%b, want 1 1", rx_busy, m_valid);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (m_valid !== 1'b0 || m_data !== '0 || rx_busy !== 1'b0 || m_frame_err !== 1'b0 ||
            m_parity_err !== 1'b0 || rx_overrun !== 1'b0) begin
            fails++;
            $display("FAIL midrst_outputs: got v=%b d=%h b=%b fe=%b pe=%b o=%b, want all 0",
                     m_valid, m_data, rx_busy, m_frame_err, m_parity_err, rx_overrun);
        end
        rx_in = 1'b1;
        step(10);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        step(20);
        clear_logs();
        send_frame(8'h5A, 1'b1, 1'b0, c0);
        exp_q.push_back(model(8'h5A, 1'b1, 1'b0));
        rx_in = 1'b1;
        step(100);
        compare_queues("midrst_next");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_break();
        test_overrun();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

Standalone UART receiver with 16x oversampling, mid-bit sampling, framing/parity checking and a one-entry valid/ready output buffer. It sits between the asynchronous serial pin and the byte-stream consumer, and is the receive-side counterpart to the existing TX path. It replaces bit-count-only RX state logic with a real bit-timed receiver.

## Interface
- `BAUD_DIV`, 27: clk cycles per oversample tick (50 MHz / 115200 / 16); legal range ≥ 2
- `OVERSAMPLE`, 16: ticks per bit; must be even, ≥ 4
- `DATA_BITS`, 8: data bits per frame, 5..8, LSB first
- `clk` input 1: single clock
- `rst_n` input 1: reset, asynchronous, active-low
- `rx_in` input 1: serial line, asynchronous to `clk`, idle high
- `m_valid` output 1: byte available
- `m_ready` input 1: consumer accepts byte
- `m_data` output DATA_BITS: received byte
- `m_frame_err` output 1: sideband with `m_data`; stop bit sampled 0
- `m_parity_err` output 1: sideband with `m_data`; 0 when parity compiled out
- `rx_busy` output 1: state ≠ RX_IDLE
- `rx_overrun` output 1: one-cycle pulse, completed byte dropped

## Operation
- Reset values: `m_valid`=0, `m_data`=0, `m_frame_err`=0, `m_parity_err`=0, `rx_busy`=0, `rx_overrun`=0; both synchroniser flops and the edge-detect history reset to 1; state RX_IDLE; all counters 0.
- `rx_in` passes through a 2-flop synchroniser. Only the synchronised value is used.
- Tick counter counts 0..BAUD_DIV-1 and emits `tick` at BAUD_DIV-1. It is held at 0 in RX_IDLE. Sample counter counts ticks 0..OVERSAMPLE-1.
- RX_IDLE: on a synchronised falling edge (prev=1, cur=0), go to RX_START and clear the counters.
- RX_START: at tick OVERSAMPLE/2, sample the line.
  - 0: go to RX_DATA and clear the sample counter.
  - 1: glitch; go back to RX_IDLE with no flag.
- RX_DATA: every OVERSAMPLE ticks, sample the line and shift it in LSB first. After DATA_BITS samples, go to RX_PARITY (if compiled in) or RX_STOP.
- RX_PARITY: after OVERSAMPLE ticks, sample the line. Error if the XOR of the data bits and the parity bit is ≠ 0 (even parity).
- RX_STOP: after OVERSAMPLE ticks, sample the line. 0 sets frame error. Then attempt the buffer load and go to RX_IDLE in the same cycle.
- Buffer load:
  - Buffer empty, or `m_valid && m_ready` in the same cycle: capture data and errors; `m_valid`=1 next cycle.
  - Otherwise: drop the new byte, keep the old one, pulse `rx_overrun` for one cycle.
- `m_valid` clears the cycle after a `m_valid && m_ready` handshake, unless a new load occurs in that cycle.
- Line held low after a framing error (break): no retrigger. RX_IDLE requires a 1→0 edge.
- Asynchronous reset mid-frame: partial byte discarded, buffer cleared, no flags raised.

## Timing
- Synchroniser latency: 2 cycles. Edge detect: +1 cycle.
- One bit period is BAUD_DIV·OVERSAMPLE cycles; each sample is taken at the bit centre ±1 tick.
- Stop bit is sampled (DATA_BITS + 1 [+1 parity] + 0.5) bit periods after the detected edge. `m_valid` rises 1 cycle after that sample.
- `m_data`, `m_frame_err` and `m_parity_err` are stable while `m_valid`=1 and no handshake has occurred.
- `m_ready` may be held high constantly. The bus is throughput-limited by line rate only.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - RX_PARITY state present; frames carry one even-parity bit before the stop bit.
  - `m_parity_err` reflects the check.
- `UART_RX_PARITY_EN` undefined:
  - RX_PARITY is unreachable and its logic is removed; RX_DATA goes directly to RX_STOP.
  - `m_parity_err` is tied to 0.
  - Frame length is 1 + DATA_BITS + 1 bits.

## Structure
- Package `uart_pkg`:
  - `rx_state_t` enum, logic [2:0]: RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP.
  - Default constants `UART_OVERSAMPLE`=16 and `UART_DATA_BITS`=8, shared with the TX side.
- One sub-module, `uart_baud_tick`: the BAUD_DIV tick counter with a synchronous clear input. It is reusable by the transmitter.
- Synchroniser, FSM, shift register and output buffer stay in the top module.

## Test plan
- Params BAUD_DIV=4, OVERSAMPLE=16, `m_ready`=1. Drive frame 0xA5 at 64 cycles/bit → one `m_valid` pulse, `m_data`=0xA5, `m_frame_err`=0, `m_valid` 1 cycle after the stop-bit centre.
- `rx_in` low pulse of 20 cycles (< half bit) → no `m_valid`, `rx_busy` returns to 0, no flags.
- Frame 0x3C with stop bit driven 0, then line held low for 500 cycles → one byte 0x3C with `m_frame_err`=1, no second frame after it.
- `m_ready`=0, send 0x11 then 0x22 → `m_data` stays 0x11, one `rx_overrun` pulse at the second stop sample. Raise `m_ready` → 0x11 is accepted, `m_valid` falls.
- Parity build: send 0x07 with parity bit 0 (wrong) → `m_parity_err`=1. Send 0x07 with parity bit 1 → `m_parity_err`=0.
- Assert `rst_n`=0 midway through the RX_DATA bits → all outputs at reset values immediately. The next clean frame 0x5A is received correctly.
